jump_debounce: RTL and testbench

JUMP_DEBOUNCE -- requirements
Module: jump_debounce

---
 rtl/jump_debounce_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/jump_debounce.sv | 140 ++++++++++++++
 tb/tb_jump_debounce.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jump_debounce_pkg.sv
// Shared types and defaults for the jump push-button debouncer.
// State encoding is fixed so other blocks can decode it directly.
package jump_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b10,
        S_WAIT_LOW  = 2'b11
    } deb_state_t;

    localparam int unsigned DEF_DEB_CYCLES  = 1000000;
    localparam int unsigned DEF_HOLD_CYCLES = 100000000;

    // S_HIGH and S_WAIT_LOW both mean "accepted level is pressed".
    function automatic logic is_pressed(deb_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Ports: clock, reset_n (async clear), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jump_debounce.sv
// Debouncer for the Jump push button with press/release/long-press pulses.
// Ports: clock, reset_n, button_raw in; jump, jump_rise, jump_fall, jump_long out.
module jump_debounce
    import jump_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_raw,
    output logic jump,
    output logic jump_rise,
    output logic jump_fall,
    output logic jump_long
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              btn_s;
    deb_state_t        state_q;
    deb_state_t        state_d;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              deb_clr;
    logic              deb_inc;
    logic              deb_done;
    logic              press_ok;
    logic              long_done;
    logic              long_fire;

    sync_2ff u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (button_raw),
        .q       (btn_s)
    );

    assign deb_done = (deb_cnt == DEB_LAST);

    always_comb begin
        state_d = state_q;
        deb_clr = 1'b0;
        deb_inc = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (btn_s) begin
                    state_d = S_WAIT_HIGH;
                    deb_clr = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (!btn_s) begin
                    state_d = S_LOW;
                end else if (deb_done) begin
                    state_d = S_HIGH;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_s) begin
                    state_d = S_WAIT_LOW;
                    deb_clr = 1'b1;
                end
            end
            S_WAIT_LOW: begin
                if (btn_s) begin
                    state_d = S_HIGH;
                end else if (deb_done) begin
                    state_d = S_LOW;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            default: state_d = S_LOW;
        endcase
    end

    // Only a qualified press restarts the hold timer; a release glitch
    // (S_WAIT_LOW back to S_HIGH) is the same press and keeps counting.
    assign press_ok  = (state_q == S_WAIT_HIGH) && (state_d == S_HIGH);
    assign long_fire = is_pressed(state_q) && (hold_cnt == HOLD_LAST)
                       && !long_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt <= '0;
        end else if (deb_clr) begin
            deb_cnt <= '0;
        end else if (deb_inc) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if (press_ok) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else begin
            if (is_pressed(state_q) && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (long_fire) begin
                long_done <= 1'b1;
            end
        end
    end

    // jump lags the state by one flop so rise/fall pulses can be derived
    // from the registered level and line up with its first new cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            jump      <= 1'b0;
            jump_rise <= 1'b0;
            jump_fall <= 1'b0;
            jump_long <= 1'b0;
        end else begin
            jump      <= is_pressed(state_q);
            jump_rise <= is_pressed(state_q) && !jump;
            jump_fall <= !is_pressed(state_q) && jump;
            jump_long <= long_fire;
        end
    end

endmodule

// File: tb/tb_jump_debounce.sv
// Self-checking bench for jump_debounce with DEB_CYCLES=4, HOLD_CYCLES=8.
// Directed scenarios plus random bounce, checked against a reference model.
module tb_jump_debounce;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    typedef struct packed {
        logic j;
        logic r;
        logic f;
        logic l;
    } exp_t;

    logic clock;
    logic reset_n;
    logic button_raw;
    logic jump;
    logic jump_rise;
    logic jump_fall;
    logic jump_long;

    jump_debounce #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .button_raw (button_raw),
        .jump       (jump),
        .jump_rise  (jump_rise),
        .jump_fall  (jump_fall),
        .jump_long  (jump_long)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_total;
    int   n_pass;
    exp_t sb[$];
    logic m_lvl;
    int   m_run;
    int   m_hi;
    int   ecnt;
    int   n_rise;
    int   n_fall;
    int   n_long;
    int   long_edge;
    int   rise_edge;
    logic last_rise;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs after edge n follow the model decision for the sample at
    // edge n-3, so the queue is primed with three idle entries.
    task automatic model_reset();
        sb.delete();
        repeat (3) sb.push_back('0);
        m_lvl     = 1'b0;
        m_run     = 0;
        m_hi      = 0;
        ecnt      = 0;
        last_rise = 1'b0;
    endtask

    task automatic model_push(input logic b);
        exp_t e;
        logic prev;
        prev = m_lvl;
        if (b != m_lvl) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
            m_lvl = ~m_lvl;
            m_run = 0;
        end
        m_hi = m_lvl ? m_hi + 1 : 0;
        e.j = m_lvl;
        e.r = m_lvl && !prev;
        e.f = !m_lvl && prev;
        e.l = (m_hi == HOLD);
        sb.push_back(e);
    endtask

    task automatic step(input logic b);
        exp_t e;
        button_raw = b;
        @(posedge clock);
        model_push(b);
        #1;
        e = sb.pop_front();
        check("sb_jump", jump, e.j);
        check("sb_rise", jump_rise, e.r);
        check("sb_fall", jump_fall, e.f);
        check("sb_long", jump_long, e.l);
        check("excl", 32'(jump_rise) + 32'(jump_fall) + 32'(jump_long) > 1,
              0);
        if (jump_rise) begin
            check("alt_rise", last_rise, 1'b0);
            last_rise = 1'b1;
            n_rise++;
            rise_edge = ecnt;
        end
        if (jump_fall) begin
            check("alt_fall", last_rise, 1'b1);
            last_rise = 1'b0;
            n_fall++;
        end
        if (jump_long) begin
            n_long++;
            long_edge = ecnt;
        end
        ecnt++;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        check("rst_jump", jump, 0);
        check("rst_pulses", {jump_rise, jump_fall, jump_long}, 0);
        repeat (cycles) begin
            @(posedge clock);
            #1;
            check("rst_hold", {jump, jump_rise, jump_fall, jump_long}, 0);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int e0;
        int lv;
        int len;
        n_total    = 0;
        n_pass     = 0;
        n_rise     = 0;
        n_fall     = 0;
        n_long     = 0;
        long_edge  = -1;
        rise_edge  = -1;
        button_raw = 1'b0;
        reset_n    = 1'b0;
        model_reset();
        @(negedge clock);
        do_reset(2);

        // Clean press at edge 10.
        repeat (10) step(1'b0);
        repeat (7) step(1'b1);
        check("press_e16_jump", jump, 0);
        step(1'b1);
        check("press_e17_jump", jump, 1);
        check("press_e17_rise", jump_rise, 1);
        check("press_e17_fall", jump_fall, 0);
        step(1'b1);
        check("press_e18_rise", jump_rise, 0);

        // Long press: hold 20 cycles past acceptance.
        repeat (18) step(1'b1);
        check("long_count", n_long, 1);
        check("long_delay", long_edge - rise_edge, 7);

        // Release glitch, then sustained release.
        n_fall = 0;
        step(1'b0);
        step(1'b0);
        repeat (10) step(1'b1);
        check("glitch_jump", jump, 1);
        check("glitch_nofall", n_fall, 0);
        repeat (7) step(1'b0);
        check("rel_e6_fall", jump_fall, 0);
        step(1'b0);
        check("rel_e7_fall", jump_fall, 1);
        check("rel_e7_jump", jump, 0);
        check("rel_fall_count", n_fall, 1);
        repeat (4) step(1'b0);

        // Bounce, then stable high.
        n_rise = 0;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        e0 = ecnt;
        repeat (7) step(1'b1);
        check("bounce_early", jump, 0);
        step(1'b1);
        check("bounce_jump", jump, 1);
        check("bounce_edge", rise_edge - e0, 7);
        repeat (3) step(1'b1);
        check("bounce_rises", n_rise, 1);

        // Reset while pressed, button still held afterwards.
        n_fall = 0;
        n_rise = 0;
        button_raw = 1'b1;
        do_reset(3);
        repeat (7) step(1'b1);
        check("rst_e6_jump", jump, 0);
        step(1'b1);
        check("rst_e7_rise", jump_rise, 1);
        check("rst_nofall", n_fall, 0);
        repeat (4) step(1'b1);

        // Random bounce runs.
        for (int r = 0; r < 60; r++) begin
            lv  = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            for (int i = 0; i < len; i++) step(lv[0]);
        end
        repeat (12) step(1'b0);
        check("final_jump", jump, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
